// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single processor-side memory port between the data-side
//   requester (port D, loads/stores) and the fetch-side requester (port I).
//   One command is granted per cycle. The owner of every outstanding load tag
//   is recorded so that returning data can be routed by mem2proc_tag.
//   A per-port squash kills that port's outstanding loads so that their data
//   is dropped on return.
//
// Handshake: a requester raises x_cmd (valid) together with x_addr/x_data/x_size.
//   It holds all of them stable until x_ack is seen high in a cycle. x_ack is
//   high in the same cycle that memory answers with a nonzero
//   mem2proc_response while that port drives proc2mem_*. Once a port has been
//   driven and not yet accepted, it keeps the bus until it is accepted or
//   drops x_cmd to BUS_NONE.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   d_cmd/d_addr/d_data/d_size  D request (BUS_NONE/BUS_LOAD/BUS_STORE)
//   d_ack                      D command accepted this cycle
//   d_data_valid, d_rdata      D load data returning this cycle
//   d_squash                   kill all D loads outstanding at this edge
//   i_*                        same set for the fetch port
//   proc2mem_*                 command/address/data/size to memory
//   mem2proc_response          nonzero = command accepted with this tag
//   mem2proc_data/_tag         returned data and its tag (tag 0 = none)
//   dbg_state                  arbiter FSM state
//   dbg_d_outstanding          D load tags in flight
//   dbg_i_outstanding          I load tags in flight
module mem_bus_arbiter #(
   parameter int XLEN            = 32,
   parameter int SIZE_W          = 2,
   parameter int MAX_WAIT        = 8,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        d_cmd,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [63:0]       d_data,
   input  logic [SIZE_W-1:0] d_size,
   output logic              d_ack,
   output logic              d_data_valid,
   output logic [63:0]       d_rdata,
   input  logic              d_squash,
   input  logic [1:0]        i_cmd,
   input  logic [XLEN-1:0]   i_addr,
   input  logic [63:0]       i_data,
   input  logic [SIZE_W-1:0] i_size,
   output logic              i_ack,
   output logic              i_data_valid,
   output logic [63:0]       i_rdata,
   input  logic              i_squash,
   output logic [1:0]        proc2mem_command,
   output logic [XLEN-1:0]   proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   output logic [SIZE_W-1:0] proc2mem_size,
   input  logic [3:0]        mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [3:0]        mem2proc_tag,
   output logic [1:0]        dbg_state,
   output logic [3:0]        dbg_d_outstanding,
   output logic [3:0]        dbg_i_outstanding
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [3:0] CAP       = 4'(MAX_OUTSTANDING);
   localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD_D = 2'd1, HOLD_I = 2'd2} state_t;

   state_t      state;
   logic [3:0]  i_wait;
   logic [3:0]  d_cnt, d_cnt_n;
   logic [3:0]  i_cnt, i_cnt_n;
   // Tag table, one bit per tag value; tag_owner is 1 for port I.
   logic [15:0] tag_valid, tag_owner, tag_live;
   logic [15:0] tag_valid_n, tag_owner_n, tag_live_n, squash_mask;

   logic d_req, i_req, d_elig, i_elig;
   logic sel_d, sel_i, accept, acc_load, ret_hit, ret_owner_i;

   // A port sitting at its load cap may still issue stores.
   assign d_req  = (d_cmd != BUS_NONE);
   assign i_req  = (i_cmd != BUS_NONE);
   assign d_elig = d_req && !((d_cmd == BUS_LOAD) && (d_cnt >= CAP));
   assign i_elig = i_req && !((i_cmd == BUS_LOAD) && (i_cnt >= CAP));

   // Port selection. A held port keeps the bus; otherwise D has priority
   // unless I has already lost MAX_WAIT times in a row.
   always_comb begin
      sel_d = 1'b0;
      sel_i = 1'b0;
      case (state)
         HOLD_D:  sel_d = d_req;
         HOLD_I:  sel_i = i_req;
         default: begin
            if (i_elig && (i_wait == WAIT_MAX)) sel_i = 1'b1;
            else if (d_elig)                    sel_d = 1'b1;
            else if (i_elig)                    sel_i = 1'b1;
         end
      endcase
      // Outputs read as zero for the whole time reset is asserted.
      if (!reset_n) begin
         sel_d = 1'b0;
         sel_i = 1'b0;
      end
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = '0;
      if (sel_d) begin
         proc2mem_command = d_cmd;
         proc2mem_addr    = d_addr;
         proc2mem_data    = d_data;
         proc2mem_size    = d_size;
      end else if (sel_i) begin
         proc2mem_command = i_cmd;
         proc2mem_addr    = i_addr;
         proc2mem_data    = i_data;
         proc2mem_size    = i_size;
      end
   end

   assign accept   = (sel_d || sel_i) && (mem2proc_response != 4'd0);
   assign acc_load = accept && (proc2mem_command == BUS_LOAD);
   assign d_ack    = accept && sel_d;
   assign i_ack    = accept && sel_i;

   // Return path: only tags that are still recorded produce anything, and only
   // live ones reach the requester.
   assign ret_hit      = reset_n && (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
   assign ret_owner_i  = tag_owner[mem2proc_tag];
   assign d_data_valid = ret_hit && !ret_owner_i && tag_live[mem2proc_tag];
   assign i_data_valid = ret_hit &&  ret_owner_i && tag_live[mem2proc_tag];
   assign d_rdata      = d_data_valid ? mem2proc_data : 64'd0;
   assign i_rdata      = i_data_valid ? mem2proc_data : 64'd0;

   // Next tag table: squash first, then the return clears its entry, then a new
   // accept writes its entry so that reuse of the same tag in one cycle keeps
   // the new load.
   always_comb begin
      squash_mask = tag_valid & ((d_squash ? ~tag_owner : 16'h0) |
                                 (i_squash ?  tag_owner : 16'h0));
      tag_valid_n = tag_valid;
      tag_owner_n = tag_owner;
      tag_live_n  = tag_live & ~squash_mask;
      if (ret_hit) tag_valid_n[mem2proc_tag] = 1'b0;
      if (acc_load) begin
         tag_valid_n[mem2proc_response] = 1'b1;
         tag_owner_n[mem2proc_response] = sel_i;
         tag_live_n[mem2proc_response]  = sel_i ? !i_squash : !d_squash;
      end
   end

   always_comb begin
      d_cnt_n = d_cnt;
      i_cnt_n = i_cnt;
      if (acc_load && sel_d) d_cnt_n = d_cnt_n + 4'd1;
      if (acc_load && sel_i) i_cnt_n = i_cnt_n + 4'd1;
      if (ret_hit && !ret_owner_i && (d_cnt != 4'd0)) d_cnt_n = d_cnt_n - 4'd1;
      if (ret_hit &&  ret_owner_i && (i_cnt != 4'd0)) i_cnt_n = i_cnt_n - 4'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         i_wait    <= 4'd0;
         d_cnt     <= 4'd0;
         i_cnt     <= 4'd0;
         tag_valid <= 16'h0;
         tag_owner <= 16'h0;
         tag_live  <= 16'h0;
      end else begin
         if (sel_d && !accept)      state <= HOLD_D;
         else if (sel_i && !accept) state <= HOLD_I;
         else                       state <= IDLE;

         // Starvation counter: counts cycles I was ready but lost the bus.
         if (i_ack || !i_req)                                  i_wait <= 4'd0;
         else if (i_elig && !sel_i && (i_wait != WAIT_MAX))    i_wait <= i_wait + 4'd1;

         d_cnt     <= d_cnt_n;
         i_cnt     <= i_cnt_n;
         tag_valid <= tag_valid_n;
         tag_owner <= tag_owner_n;
         tag_live  <= tag_live_n;
      end
   end

   assign dbg_state         = state;
   assign dbg_d_outstanding = d_cnt;
   assign dbg_i_outstanding = i_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by a randomized
// run checked against a tag-ownership reference model.
module tb_mem_bus_arbiter;

   localparam int XLEN     = 32;
   localparam int SIZE_W   = 2;
   localparam int MAX_WAIT = 8;
   localparam int MAX_OUT  = 8;
   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   // ---------------- clock / reset / DUT ----------------
   logic              clock = 1'b0;
   logic              reset_n;
   logic [1:0]        d_cmd, i_cmd;
   logic [XLEN-1:0]   d_addr, i_addr;
   logic [63:0]       d_data, i_data;
   logic [SIZE_W-1:0] d_size, i_size;
   logic              d_ack, i_ack, d_data_valid, i_data_valid;
   logic [63:0]       d_rdata, i_rdata;
   logic              d_squash, i_squash;
   logic [1:0]        proc2mem_command;
   logic [XLEN-1:0]   proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic [SIZE_W-1:0] proc2mem_size;
   logic [3:0]        mem2proc_response, mem2proc_tag;
   logic [63:0]       mem2proc_data;
   logic [1:0]        dbg_state;
   logic [3:0]        dbg_d_outstanding, dbg_i_outstanding;

   always #5 clock = ~clock;

   mem_bus_arbiter #(.XLEN(XLEN), .SIZE_W(SIZE_W), .MAX_WAIT(MAX_WAIT), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .d_cmd(d_cmd), .d_addr(d_addr), .d_data(d_data), .d_size(d_size),
      .d_ack(d_ack), .d_data_valid(d_data_valid), .d_rdata(d_rdata), .d_squash(d_squash),
      .i_cmd(i_cmd), .i_addr(i_addr), .i_data(i_data), .i_size(i_size),
      .i_ack(i_ack), .i_data_valid(i_data_valid), .i_rdata(i_rdata), .i_squash(i_squash),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .dbg_state(dbg_state), .dbg_d_outstanding(dbg_d_outstanding),
      .dbg_i_outstanding(dbg_i_outstanding)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   // m_owner[t]: -1 free, 0 = D, 1 = I. m_holder: 0 nobody, 1 D, 2 I keeps the bus.
   int m_owner[16];
   bit m_live[16];
   int m_holder;
   int m_wait;

   // Values predicted for the current cycle.
   int                e_pick;
   bit                e_acc, s_i_ok;
   logic              e_d_ack, e_i_ack, e_d_dv, e_i_dv;
   logic [63:0]       e_d_rdata, e_i_rdata, e_data;
   logic [1:0]        e_cmd;
   logic [XLEN-1:0]   e_addr;
   logic [SIZE_W-1:0] e_size;
   logic [3:0]        e_d_cnt, e_i_cnt;

   function automatic int owned(input int who);
      int n = 0;
      for (int k = 1; k < 16; k++) if (m_owner[k] == who) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 16; k++) begin
         m_owner[k] = -1;
         m_live[k]  = 1'b0;
      end
      m_holder = 0;
      m_wait   = 0;
   endtask

   // Predict this cycle's outputs at the falling edge from the model and inputs.
   task automatic sample();
      int dn, inn;
      bit d_req, i_req, d_ok;
      @(negedge clock);
      dn     = owned(0);
      inn    = owned(1);
      d_req  = (d_cmd != NONE);
      i_req  = (i_cmd != NONE);
      d_ok   = d_req && !(d_cmd == LOAD && dn >= MAX_OUT);
      s_i_ok = i_req && !(i_cmd == LOAD && inn >= MAX_OUT);
      e_pick = 0;
      if (m_holder == 1)                    e_pick = d_req ? 1 : 0;
      else if (m_holder == 2)               e_pick = i_req ? 2 : 0;
      else if (s_i_ok && m_wait == MAX_WAIT) e_pick = 2;
      else if (d_ok)                        e_pick = 1;
      else if (s_i_ok)                      e_pick = 2;
      e_acc   = (e_pick != 0) && (mem2proc_response != 4'd0);
      e_d_ack = e_acc && (e_pick == 1);
      e_i_ack = e_acc && (e_pick == 2);
      e_cmd = NONE; e_addr = '0; e_data = '0; e_size = '0;
      if (e_pick == 1) begin e_cmd = d_cmd; e_addr = d_addr; e_data = d_data; e_size = d_size; end
      if (e_pick == 2) begin e_cmd = i_cmd; e_addr = i_addr; e_data = i_data; e_size = i_size; end
      e_d_dv = 1'b0; e_i_dv = 1'b0; e_d_rdata = '0; e_i_rdata = '0;
      if (mem2proc_tag != 4'd0 && m_owner[mem2proc_tag] != -1 && m_live[mem2proc_tag]) begin
         if (m_owner[mem2proc_tag] == 0) begin e_d_dv = 1'b1; e_d_rdata = mem2proc_data; end
         else begin e_i_dv = 1'b1; e_i_rdata = mem2proc_data; end
      end
      e_d_cnt = 4'(dn);
      e_i_cnt = 4'(inn);
   endtask

   // Apply the clock edge to the model, then move to just after the DUT edge.
   task automatic advance();
      int t;
      if (i_cmd == NONE || e_i_ack) m_wait = 0;
      else if (s_i_ok && e_pick != 2 && m_wait < MAX_WAIT) m_wait++;
      m_holder = (e_pick != 0 && !e_acc) ? e_pick : 0;
      for (int k = 1; k < 16; k++) begin
         if (m_owner[k] == 0 && d_squash) m_live[k] = 1'b0;
         if (m_owner[k] == 1 && i_squash) m_live[k] = 1'b0;
      end
      if (mem2proc_tag != 4'd0) m_owner[mem2proc_tag] = -1;
      if (e_acc && e_cmd == LOAD) begin
         t = int'(mem2proc_response);
         m_owner[t] = e_pick - 1;
         m_live[t]  = (e_pick == 1) ? !d_squash : !i_squash;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      d_cmd = NONE; d_addr = '0; d_data = '0; d_size = '0; d_squash = 1'b0;
      i_cmd = NONE; i_addr = '0; i_data = '0; i_size = '0; i_squash = 1'b0;
      mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      model_clear();
      clear_inputs();
      d_cmd = LOAD; i_cmd = LOAD; d_addr = 32'h55; i_addr = 32'h66;
      mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'hFF;
      repeat (2) @(posedge clock);
      @(negedge clock);
      vectors++; if (proc2mem_command !== NONE) begin miscompares++; $display("FAIL reset_cmd: got %0d want 0", proc2mem_command); end
      vectors++; if (proc2mem_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", proc2mem_addr); end
      vectors++; if ({d_ack, i_ack, d_data_valid, i_data_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {d_ack, i_ack, d_data_valid, i_data_valid}); end
      vectors++; if ({dbg_d_outstanding, dbg_i_outstanding} !== 8'h0) begin miscompares++; $display("FAIL reset_counts: got %h want 00", {dbg_d_outstanding, dbg_i_outstanding}); end
      clear_inputs();
      @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_d_load();
      d_cmd = LOAD; d_addr = 32'h100; d_size = 2'd3; mem2proc_response = 4'd3;
      sample();
      vectors++; if (d_ack !== 1'b1) begin miscompares++; $display("FAIL t1_d_ack: got %b want 1", d_ack); end
      vectors++; if (proc2mem_addr !== 32'h100) begin miscompares++; $display("FAIL t1_addr: got %h want 100", proc2mem_addr); end
      vectors++; if (proc2mem_command !== LOAD) begin miscompares++; $display("FAIL t1_cmd: got %0d want 1", proc2mem_command); end
      advance();
      d_cmd = NONE; mem2proc_response = 4'd0; mem2proc_tag = 4'd3; mem2proc_data = 64'hAB;
      sample();
      vectors++; if (d_data_valid !== 1'b1) begin miscompares++; $display("FAIL t1_d_valid: got %b want 1", d_data_valid); end
      vectors++; if (d_rdata !== 64'hAB) begin miscompares++; $display("FAIL t1_d_rdata: got %h want ab", d_rdata); end
      vectors++; if (i_data_valid !== 1'b0) begin miscompares++; $display("FAIL t1_i_valid: got %b want 0", i_data_valid); end
      advance();
      mem2proc_tag = 4'd0;
      sample();
      vectors++; if (dbg_d_outstanding !== 4'd0) begin miscompares++; $display("FAIL t1_d_count: got %0d want 0", dbg_d_outstanding); end
      advance();
   endtask

   task automatic test_hold();
      d_cmd = LOAD; d_addr = 32'h200; i_cmd = LOAD; i_addr = 32'h300;
      for (int c = 0; c < 3; c++) begin
         mem2proc_response = (c == 2) ? 4'd5 : 4'd0;
         sample();
         vectors++; if (proc2mem_addr !== 32'h200) begin miscompares++; $display("FAIL t2_hold_addr c%0d: got %h want 200", c, proc2mem_addr); end
         vectors++; if (d_ack !== (c == 2)) begin miscompares++; $display("FAIL t2_d_ack c%0d: got %b want %b", c, d_ack, c == 2); end
         vectors++; if (i_ack !== 1'b0) begin miscompares++; $display("FAIL t2_i_ack c%0d: got %b want 0", c, i_ack); end
         advance();
      end
      d_cmd = NONE; mem2proc_response = 4'd6;
      sample();
      vectors++; if (proc2mem_addr !== 32'h300) begin miscompares++; $display("FAIL t2_i_addr: got %h want 300", proc2mem_addr); end
      vectors++; if (i_ack !== 1'b1) begin miscompares++; $display("FAIL t2_i_win: got %b want 1", i_ack); end
      advance();
      i_cmd = NONE; mem2proc_response = 4'd0; mem2proc_tag = 4'd5; mem2proc_data = 64'h1234_5678_9ABC_DEF0;
      sample();
      vectors++; if (d_data_valid !== 1'b1 || d_rdata !== 64'h1234_5678_9ABC_DEF0) begin miscompares++; $display("FAIL t2_d_ret: got %b/%h want 1/123456789abcdef0", d_data_valid, d_rdata); end
      advance();
      mem2proc_tag = 4'd6; mem2proc_data = 64'h77;
      sample();
      vectors++; if (i_data_valid !== 1'b1 || i_rdata !== 64'h77 || d_data_valid !== 1'b0) begin miscompares++; $display("FAIL t2_i_ret: got %b/%h/%b want 1/77/0", i_data_valid, i_rdata, d_data_valid); end
      advance();
      mem2proc_tag = 4'd0;
   endtask

   task automatic test_starvation();
      int waited = 0;
      bit got = 1'b0;
      d_cmd = STORE; i_cmd = LOAD; i_addr = 32'h400; mem2proc_response = 4'd7;
      while (!got && waited < 2 * MAX_WAIT + 4) begin
         d_addr = $urandom;
         sample();
         waited++;
         if (i_ack === 1'b1) got = 1'b1;
         else begin
            vectors++; if (d_ack !== 1'b1) begin miscompares++; $display("FAIL t3_d_ack cyc%0d: got %b want 1", waited, d_ack); end
         end
         advance();
      end
      vectors++; if (!got || waited > MAX_WAIT + 1) begin miscompares++; $display("FAIL t3_i_starve: acked=%b after %0d cycles, want ack within %0d", got, waited, MAX_WAIT + 1); end
      d_cmd = NONE; i_cmd = NONE; mem2proc_response = 4'd0; mem2proc_tag = 4'd7; mem2proc_data = 64'h3C;
      sample();
      vectors++; if (i_data_valid !== 1'b1 || i_rdata !== 64'h3C) begin miscompares++; $display("FAIL t3_i_ret: got %b/%h want 1/3c", i_data_valid, i_rdata); end
      advance();
      mem2proc_tag = 4'd0;
   endtask

   task automatic test_squash();
      i_cmd = LOAD;
      for (int t = 1; t <= 2; t++) begin
         i_addr = 32'(t * 64); mem2proc_response = 4'(t);
         sample();
         vectors++; if (i_ack !== 1'b1) begin miscompares++; $display("FAIL t4_i_ack tag%0d: got %b want 1", t, i_ack); end
         advance();
      end
      i_cmd = NONE; mem2proc_response = 4'd0; i_squash = 1'b1;
      sample();
      vectors++; if (dbg_i_outstanding !== 4'd2) begin miscompares++; $display("FAIL t4_i_count: got %0d want 2", dbg_i_outstanding); end
      advance();
      i_squash = 1'b0;
      for (int t = 1; t <= 2; t++) begin
         mem2proc_tag = 4'(t); mem2proc_data = 64'hDEAD;
         sample();
         vectors++; if (i_data_valid !== 1'b0 || d_data_valid !== 1'b0) begin miscompares++; $display("FAIL t4_dead_ret tag%0d: got %b%b want 00", t, i_data_valid, d_data_valid); end
         advance();
      end
      mem2proc_tag = 4'd0;
      sample();
      vectors++; if (dbg_i_outstanding !== 4'd0) begin miscompares++; $display("FAIL t4_i_drain: got %0d want 0", dbg_i_outstanding); end
      advance();
   endtask

   task automatic test_cap();
      d_cmd = LOAD;
      for (int t = 1; t <= MAX_OUT; t++) begin
         d_addr = 32'(t * 16); mem2proc_response = 4'(t);
         sample();
         vectors++; if (d_ack !== 1'b1) begin miscompares++; $display("FAIL t5_load_ack tag%0d: got %b want 1", t, d_ack); end
         advance();
      end
      mem2proc_response = 4'd9;
      sample();
      vectors++; if (dbg_d_outstanding !== 4'(MAX_OUT)) begin miscompares++; $display("FAIL t5_count: got %0d want %0d", dbg_d_outstanding, MAX_OUT); end
      vectors++; if (proc2mem_command !== NONE || d_ack !== 1'b0) begin miscompares++; $display("FAIL t5_capped: got cmd %0d ack %b want 0/0", proc2mem_command, d_ack); end
      advance();
      d_cmd = STORE; d_data = 64'h5A5A;
      sample();
      vectors++; if (d_ack !== 1'b1 || proc2mem_command !== STORE || proc2mem_data !== 64'h5A5A) begin miscompares++; $display("FAIL t5_store: got ack %b cmd %0d data %h want 1/2/5a5a", d_ack, proc2mem_command, proc2mem_data); end
      advance();
      d_cmd = LOAD; mem2proc_tag = 4'd1; mem2proc_data = 64'h11;
      sample();
      vectors++; if (proc2mem_command !== NONE || d_data_valid !== 1'b1) begin miscompares++; $display("FAIL t5_free_one: got cmd %0d valid %b want 0/1", proc2mem_command, d_data_valid); end
      advance();
      mem2proc_tag = 4'd0;
      sample();
      vectors++; if (d_ack !== 1'b1 || proc2mem_command !== LOAD) begin miscompares++; $display("FAIL t5_resume: got ack %b cmd %0d want 1/1", d_ack, proc2mem_command); end
      advance();
      d_cmd = NONE; mem2proc_response = 4'd0;
      for (int t = 2; t <= 9; t++) begin
         mem2proc_tag = 4'(t); mem2proc_data = 64'(t * 3);
         sample();
         vectors++; if (d_data_valid !== 1'b1 || d_rdata !== 64'(t * 3)) begin miscompares++; $display("FAIL t5_drain tag%0d: got %b/%h want 1/%h", t, d_data_valid, d_rdata, t * 3); end
         advance();
      end
      mem2proc_tag = 4'd0;
   endtask

   task automatic test_reset_mid();
      d_cmd = LOAD; mem2proc_response = 4'd4;
      sample(); advance();
      d_cmd = NONE; i_cmd = LOAD; i_addr = 32'h900; mem2proc_response = 4'd5;
      sample(); advance();
      mem2proc_response = 4'd0;
      sample();
      vectors++; if (i_ack !== 1'b0 || proc2mem_addr !== 32'h900) begin miscompares++; $display("FAIL t6_hold: got ack %b addr %h want 0/900", i_ack, proc2mem_addr); end
      advance();
      reset_n = 1'b0;
      #1;
      vectors++; if (proc2mem_command !== NONE || proc2mem_addr !== '0 || i_ack !== 1'b0) begin miscompares++; $display("FAIL t6_async: got cmd %0d addr %h ack %b want 0/0/0", proc2mem_command, proc2mem_addr, i_ack); end
      vectors++; if ({dbg_d_outstanding, dbg_i_outstanding} !== 8'h0) begin miscompares++; $display("FAIL t6_counts: got %h want 00", {dbg_d_outstanding, dbg_i_outstanding}); end
      model_clear();
      i_cmd = NONE;
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int t = 4; t <= 5; t++) begin
         mem2proc_tag = 4'(t); mem2proc_data = 64'hBAD;
         sample();
         vectors++; if (d_data_valid !== 1'b0 || i_data_valid !== 1'b0) begin miscompares++; $display("FAIL t6_stale tag%0d: got %b%b want 00", t, d_data_valid, i_data_valid); end
         advance();
      end
      mem2proc_tag = 4'd0;
   endtask

   // Requesters obey the handshake; memory hands out free tags, sometimes the
   // tag being returned in the same cycle, and returns outstanding or bogus tags.
   task automatic test_random();
      int t;
      bit d_done = 1'b1, i_done = 1'b1;
      reset_n = 1'b0; clear_inputs(); model_clear();
      @(posedge clock); #1 reset_n = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (d_done) begin
            d_cmd = ($urandom_range(0, 2) == 0) ? NONE : (($urandom_range(0, 1) == 0) ? LOAD : STORE);
            d_addr = $urandom; d_data = {$urandom, $urandom}; d_size = 2'($urandom);
         end
         if (i_done) begin
            i_cmd = ($urandom_range(0, 3) == 0) ? NONE : (($urandom_range(0, 3) == 0) ? STORE : LOAD);
            i_addr = $urandom; i_data = {$urandom, $urandom}; i_size = 2'($urandom);
         end
         d_squash = ($urandom_range(0, 15) == 0);
         i_squash = ($urandom_range(0, 15) == 0);
         mem2proc_data = {$urandom, $urandom};
         mem2proc_tag = 4'd0;
         t = $urandom_range(0, 9);
         if (t < 4) begin
            for (int k = 0; k < 8; k++) begin
               t = $urandom_range(1, 15);
               if (m_owner[t] != -1) begin mem2proc_tag = 4'(t); break; end
            end
         end else if (t == 4) mem2proc_tag = 4'($urandom_range(1, 15));
         mem2proc_response = 4'd0;
         if ($urandom_range(0, 2) != 0) begin
            if (mem2proc_tag != 4'd0 && m_owner[mem2proc_tag] != -1 && $urandom_range(0, 2) == 0)
               mem2proc_response = mem2proc_tag;
            else
               for (int k = 0; k < 8; k++) begin
                  t = $urandom_range(1, 15);
                  if (m_owner[t] == -1) begin mem2proc_response = 4'(t); break; end
               end
         end
         sample();
         vectors++; if (d_ack !== e_d_ack) begin miscompares++; $display("FAIL rnd_d_ack cyc%0d: got %b want %b", cyc, d_ack, e_d_ack); end
         vectors++; if (i_ack !== e_i_ack) begin miscompares++; $display("FAIL rnd_i_ack cyc%0d: got %b want %b", cyc, i_ack, e_i_ack); end
         vectors++; if (proc2mem_command !== e_cmd) begin miscompares++; $display("FAIL rnd_cmd cyc%0d: got %0d want %0d", cyc, proc2mem_command, e_cmd); end
         vectors++; if (proc2mem_addr !== e_addr) begin miscompares++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, proc2mem_addr, e_addr); end
         vectors++; if (proc2mem_data !== e_data) begin miscompares++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, proc2mem_data, e_data); end
         vectors++; if (proc2mem_size !== e_size) begin miscompares++; $display("FAIL rnd_size cyc%0d: got %0d want %0d", cyc, proc2mem_size, e_size); end
         vectors++; if (d_data_valid !== e_d_dv || d_rdata !== e_d_rdata) begin miscompares++; $display("FAIL rnd_d_ret cyc%0d: got %b/%h want %b/%h", cyc, d_data_valid, d_rdata, e_d_dv, e_d_rdata); end
         vectors++; if (i_data_valid !== e_i_dv || i_rdata !== e_i_rdata) begin miscompares++; $display("FAIL rnd_i_ret cyc%0d: got %b/%h want %b/%h", cyc, i_data_valid, i_rdata, e_i_dv, e_i_rdata); end
         vectors++; if (dbg_d_outstanding !== e_d_cnt) begin miscompares++; $display("FAIL rnd_d_count cyc%0d: got %0d want %0d", cyc, dbg_d_outstanding, e_d_cnt); end
         vectors++; if (dbg_i_outstanding !== e_i_cnt) begin miscompares++; $display("FAIL rnd_i_count cyc%0d: got %0d want %0d", cyc, dbg_i_outstanding, e_i_cnt); end
         d_done = (d_cmd == NONE) || e_d_ack;
         i_done = (i_cmd == NONE) || e_i_ack;
         advance();
      end
      clear_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_n = 1'b0;
      clear_inputs();
      model_clear();
      test_reset();
      test_d_load();
      test_hold();
      test_starvation();
      test_squash();
      test_cap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
